muldiv_seq: RTL and testbench

Multi-cycle sequencer for the RV32M multiply/divide instructions. It sits beside the single-cycle ALU in execute. When the decoder flags an M-extension op, this block latches the operands and runs an iterative shift-add multiplier or restoring divider. It holds the core with `stall` until the result is ready, then presents the result for one write-back cycle.

---
 rtl/muldiv_pkg.sv | 33 +++
 rtl/muldiv_step.sv | 53 +++++
 rtl/muldiv_seq.sv | 188 ++++++++++++++++++
 tb/tb_muldiv_seq.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
//   muldiv_op_e    : funct3 encodings of the eight M-extension ops
//   muldiv_state_e : sequencer states
//   XLEN_DEF       : default operand width
//   DIV0_Q         : quotient returned for a divide by zero
//   OVF_DIVIDEND   : the only dividend that can overflow a signed divide (by -1)
// The divider is built only when MULDIV_DIV_EN is defined.
package muldiv_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [XLEN_DEF-1:0] DIV0_Q       = 32'hFFFF_FFFF;
  localparam logic [XLEN_DEF-1:0] OVF_DIVIDEND = 32'h8000_0000;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2,
    DONE = 2'd3
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the sequential multiply/divide datapath.
// Ports:
//   is_div_i : 1 = restoring-divide step, 0 = shift-add multiply step
//   acc_i    : multiply: high product half; divide: partial remainder
//   lo_i     : multiply: low product half / remaining multiplier bits;
//              divide: dividend bits shifting out / quotient bits shifting in
//   opnd_i   : multiplicand magnitude (multiply) or divisor magnitude (divide)
//   acc_o, lo_o : updated values for the next cycle
// The divide step exists only when MULDIV_DIV_EN is defined.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div_i,
  input  logic [XLEN-1:0] acc_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] opnd_i,
  output logic [XLEN-1:0] acc_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN:0] sum;
`ifdef MULDIV_DIV_EN
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;
`else
  logic unused_is_div;
  assign unused_is_div = is_div_i;
`endif

  always_comb begin
    // Multiply: add the multiplicand when the current multiplier LSB is set,
    // then shift the whole {carry, acc, lo} right; the product fills lo from the top.
    sum   = {1'b0, acc_i} + {1'b0, {XLEN{lo_i[0]}} & opnd_i};
    acc_o = sum[XLEN:1];
    lo_o  = {sum[0], lo_i[XLEN-1:1]};
`ifdef MULDIV_DIV_EN
    // Divide: shift the next dividend bit into the remainder and keep the
    // difference only if it did not go negative (restore otherwise).
    rem_sh = {acc_i, lo_i[XLEN-1]};
    diff   = rem_sh - {1'b0, opnd_i};
    if (is_div_i) begin
      if (!diff[XLEN]) begin
        acc_o = diff[XLEN-1:0];
        lo_o  = {lo_i[XLEN-2:0], 1'b1};
      end else begin
        acc_o = rem_sh[XLEN-1:0];
        lo_o  = {lo_i[XLEN-2:0], 1'b0};
      end
    end
`endif
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle sequencer for RV32M multiply/divide, running beside the ALU.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start           : M-op present in execute (held while stalled)
//   op              : funct3 of the M-op
//   opr_a, opr_b    : rs1 / rs2 values
//   stall           : holds the core from acceptance through the FIN cycle
//   busy            : registered, high in CALC and FIN
//   done            : registered one-cycle pulse in DONE
//   result          : registered result, valid with done, held otherwise
// Define MULDIV_DIV_EN to build the divider; without it divide ops
// complete in two cycles with a zero result.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] opr_a,
  input  logic [XLEN-1:0] opr_b,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int            CW   = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  function automatic logic [XLEN-1:0] neg_if(input logic n, input logic [XLEN-1:0] v);
    return n ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_if2(input logic n, input logic [2*XLEN-1:0] v);
    return n ? -v : v;
  endfunction

  muldiv_state_e   state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  muldiv_op_e      op_q, op_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            neg_q, neg_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  muldiv_op_e      op_in;
  logic            is_div_in, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN-1:0] step_acc, step_lo;
  logic [2*XLEN-1:0] prod;

`ifdef MULDIV_DIV_EN
  // Remainder sign follows the dividend; the special-case flags bypass CALC.
  logic            a_neg_q, a_neg_d;
  logic            div0_q, div0_d;
  logic            ovf_q, ovf_d;
  logic            div0_in, ovf_in;
  logic [XLEN-1:0] quo, rem;
`endif

  assign op_in     = muldiv_op_e'(op);
  assign is_div_in = op[2];
  assign a_neg     = opr_a[XLEN-1] & (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
  assign b_neg     = opr_b[XLEN-1] & (op_in inside {OP_MULH, OP_DIV, OP_REM});
  assign a_mag     = neg_if(a_neg, opr_a);
  assign b_mag     = neg_if(b_neg, opr_b);

`ifdef MULDIV_DIV_EN
  assign div0_in = is_div_in & (opr_b == '0);
  assign ovf_in  = (op_in inside {OP_DIV, OP_REM}) &
                   (opr_a == {1'b1, {(XLEN-1){1'b0}}}) & (opr_b == '1);
`endif

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div_i (op_q[2]),
    .acc_i    (acc_q),
    .lo_i     (lo_q),
    .opnd_i   (opnd_q),
    .acc_o    (step_acc),
    .lo_o     (step_lo)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    result_d = result_q;
    neg_d    = neg_q;
    prod     = neg_if2(neg_q, {acc_q, lo_q});
`ifdef MULDIV_DIV_EN
    a_neg_d  = a_neg_q;
    div0_d   = div0_q;
    ovf_d    = ovf_q;
    quo      = neg_if(neg_q, lo_q);
    rem      = neg_if(a_neg_q, acc_q);
    if (div0_q) begin
      quo = '1;
      rem = neg_if(a_neg_q, lo_q);   // lo still holds |dividend|
    end else if (ovf_q) begin
      quo = {1'b1, {(XLEN-1){1'b0}}};
      rem = '0;
    end
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d   = op_in;
          cnt_d  = '0;
          acc_d  = '0;
          lo_d   = is_div_in ? a_mag : b_mag;
          opnd_d = is_div_in ? b_mag : a_mag;
          neg_d  = a_neg ^ b_neg;
`ifdef MULDIV_DIV_EN
          a_neg_d = a_neg;
          div0_d  = div0_in;
          ovf_d   = ovf_in;
          state_d = (div0_in | ovf_in) ? FIN : CALC;
`else
          state_d = is_div_in ? FIN : CALC;
`endif
        end
      end
      CALC: begin
        acc_d = step_acc;
        lo_d  = step_lo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = FIN;
      end
      FIN: begin
        if (op_q[2]) begin
`ifdef MULDIV_DIV_EN
          result_d = op_q[1] ? rem : quo;
`else
          result_d = '0;
`endif
        end else begin
          result_d = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == CALC) | (state_d == FIN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
    op_q   <= op_d;
    acc_q  <= acc_d;
    lo_q   <= lo_d;
    opnd_q <= opnd_d;
    neg_q  <= neg_d;
`ifdef MULDIV_DIV_EN
    a_neg_q <= a_neg_d;
    div0_q  <= div0_d;
    ovf_q   <= ovf_d;
`endif
  end

  assign stall  = (start & (state_q == IDLE)) | busy_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq (XLEN=32). Expectations for divide ops
// follow MULDIV_DIV_EN: with it defined the full RISC-V results, otherwise
// zero with two-cycle latency.
module tb_muldiv_seq;

  localparam int XLEN = 32;

  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
  localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [2:0]      op = 3'd0;
  logic [XLEN-1:0] opr_a = '0;
  logic [XLEN-1:0] opr_b = '0;
  logic            stall, busy, done;
  logic [XLEN-1:0] result;

  int vecs = 0;
  int errs = 0;

  muldiv_seq #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .opr_a  (opr_a),
    .opr_b  (opr_b),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic is_special(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_DIV_EN
    return o[2] && ((b == 32'd0) ||
           ((o == DIV || o == REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
`else
    return o[2];
`endif
  endfunction

  // Result from the architectural definition, using 64-bit integer arithmetic.
  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint    sa, sb, ua, ub, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (o)
      MUL:    begin r = sa * sb; p = r; return p[31:0];  end
      MULH:   begin r = sa * sb; p = r; return p[63:32]; end
      MULHSU: begin r = sa * ub; p = r; return p[63:32]; end
      MULHU:  begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      default: begin
`ifdef MULDIV_DIV_EN
        if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
        if ((o == DIV || o == REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          return o[1] ? 32'd0 : 32'h8000_0000;
        case (o)
          DIV:     r = sa / sb;
          DIVU:    r = ua / ub;
          REM:     r = sa % sb;
          default: r = ua % ub;
        endcase
        p = r;
        return p[31:0];
`else
        return 32'd0;
`endif
      end
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int edges;
    int scount;
    int exp_l;
    logic [31:0] exp_r;
    exp_r = ref_res(o, a, b);
    exp_l = is_special(o, a, b) ? 1 : XLEN + 1;
    @(negedge clk);
    start = 1'b1; op = o; opr_a = a; opr_b = b;
    #1 check({tag, " stall_accept"}, {31'd0, stall}, 32'd1);
    @(posedge clk);
    #1;
    // Scramble the inputs: the latched copies must be used.
    op = 3'($urandom); opr_a = $urandom; opr_b = $urandom;
    edges = 0;
    scount = 0;
    while (edges < 100) begin
      @(negedge clk);
      if (done) break;
      if (stall) scount++;
      @(posedge clk);
      edges++;
    end
    check({tag, " latency"}, edges, exp_l);
    check({tag, " stall_cycles"}, scount, exp_l);
    check({tag, " result"}, result, exp_r);
    check({tag, " stall_in_done"}, {31'd0, stall}, 32'd0);
    // start still held through the DONE edge: no second op may begin.
    @(posedge clk);
    @(negedge clk);
    check({tag, " busy_after_done"}, {31'd0, busy}, 32'd0);
    check({tag, " done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, " result_hold"}, result, exp_r);
    start = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst result", result, 32'd0);
    check("rst stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases
    run_op("mul_7x-3",   MUL,    32'h0000_0007, 32'hFFFF_FFFD);
    run_op("mulh_min",   MULH,   32'h8000_0000, 32'h8000_0000);
    run_op("mulhu_ones", MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulhsu_ones",MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div_-7_2",   DIV,    32'hFFFF_FFF9, 32'd2);
    run_op("rem_-7_2",   REM,    32'hFFFF_FFF9, 32'd2);
    run_op("divu_100_7", DIVU,   32'd100,       32'd7);
    run_op("remu_100_7", REMU,   32'd100,       32'd7);
    run_op("div_5_0",    DIV,    32'd5,         32'd0);
    run_op("rem_5_0",    REM,    32'd5,         32'd0);
    run_op("div_ovf",    DIV,    32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem_ovf",    REM,    32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem_-9_0",   REM,    32'hFFFF_FFF7, 32'd0);

    // Reset in the middle of CALC
    @(negedge clk);
    start = 1'b1; op = MUL; opr_a = 32'd7; opr_b = 32'hFFFF_FFFD;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst done", {31'd0, done}, 32'd0);
    check("midrst result", result, 32'd0);
    check("midrst stall", {31'd0, stall}, 32'd0);
    start = 1'b1;
    #1 check("midrst idle", {31'd0, stall}, 32'd1);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_op("mul_after_rst", MUL, 32'd7, 32'hFFFF_FFFD);

    // Randomized ops with occasional boundary operands
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: ra = 32'h8000_0000;
        3: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op("random", ro, ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
